// File: rtl/axi_lite_sram.sv
// axi_lite_sram -- AXI4-Lite slave memory with independent read/write channels.
//
// Holds DEPTH words of DATA_W bits starting at byte address BASE. Each channel
// has its own FSM with a programmable wait (RD_LAT / WR_LAT) between request
// capture and response. Addresses outside the window answer DECERR: reads
// return zero and writes are dropped. The storage array itself is not reset.
//
// Optional feature macro: MEM_RAND_DELAY_EN
//   When defined, a 16-bit Galois LFSR adds 0..15 extra wait cycles to each
//   transaction, sampled independently at read and write wait-state entry.
//
// Ports:
//   clk, rst                              clock, async active-low reset
//   mem_aw{valid,ready,addr}              write address channel
//   mem_w{valid,ready,data,strb}          write data channel
//   mem_b{valid,ready,resp}               write response channel
//   mem_ar{valid,ready,addr}              read address channel
//   mem_r{valid,ready,resp,data}          read data channel
module axi_lite_sram #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 1024,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 1,
  parameter int                WR_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_awvalid,
  output logic                mem_awready,
  input  logic [ADDR_W-1:0]   mem_awaddr,
  input  logic                mem_wvalid,
  output logic                mem_wready,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_bvalid,
  input  logic                mem_bready,
  output logic [1:0]          mem_bresp,
  input  logic                mem_arvalid,
  output logic                mem_arready,
  input  logic [ADDR_W-1:0]   mem_araddr,
  output logic                mem_rvalid,
  input  logic                mem_rready,
  output logic [1:0]          mem_rresp,
  output logic [DATA_W-1:0]   mem_rdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} wr_state_t;

  // Byte-lane merge: lanes with strobe set take the new data, others keep old.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [BYTES-1:0]  strb);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTES; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  rd_state_t         rd_state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [4:0]        rd_cnt_r;
  logic              arready_r, rvalid_r;
  logic [1:0]        rresp_r;
  logic [DATA_W-1:0] rdata_r;

  wr_state_t         wr_state_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [BYTES-1:0]  wr_strb_r;
  logic [4:0]        wr_cnt_r;
  logic              awready_r, wready_r, bvalid_r;
  logic [1:0]        bresp_r;

  logic [4:0]        rd_tgt_s, wr_tgt_s;

  // Address decode for both latched addresses; the offset is full width so a
  // wrap below BASE or past the window is caught by the span compare.
  logic [ADDR_W-1:0] rd_off_s, wr_off_s;
  logic              rd_hit_s, wr_hit_s;
  logic [IDX_W-1:0]  rd_idx_s, wr_idx_s;
  assign rd_off_s = rd_addr_r - BASE;
  assign wr_off_s = wr_addr_r - BASE;
  assign rd_hit_s = (rd_addr_r >= BASE) && ({1'b0, rd_off_s} < SPAN);
  assign wr_hit_s = (wr_addr_r >= BASE) && ({1'b0, wr_off_s} < SPAN);
  assign rd_idx_s = rd_off_s[IDX_W+OFF_W-1:OFF_W];
  assign wr_idx_s = wr_off_s[IDX_W+OFF_W-1:OFF_W];

  logic rd_done_s, wr_done_s, wr_commit_s;
  assign rd_done_s   = (rd_state_r == R_WAIT) && (rd_cnt_r == rd_tgt_s);
  assign wr_done_s   = (wr_state_r == W_WAIT) && (wr_cnt_r == wr_tgt_s);
  assign wr_commit_s = wr_done_s && wr_hit_s;

  // AW and W are captured independently; the pair is complete once each has
  // either been taken earlier or is being taken this cycle.
  logic aw_take_s, w_take_s, wr_both_s;
  assign aw_take_s = (wr_state_r == W_IDLE) && awready_r && mem_awvalid;
  assign w_take_s  = (wr_state_r == W_IDLE) && wready_r  && mem_wvalid;
  assign wr_both_s = (wr_state_r == W_IDLE) && (aw_take_s || !awready_r) && (w_take_s || !wready_r);

`ifdef MEM_RAND_DELAY_EN
  logic [15:0] lfsr_r;
  logic [4:0]  rd_tgt_r, wr_tgt_r;

  // Free-running Galois LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_r <= 16'hACE1;
    else      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  end

  // Per-transaction wait targets, sampled at wait-state entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_tgt_r <= 5'd0;
      wr_tgt_r <= 5'd0;
    end else begin
      if ((rd_state_r == R_IDLE) && mem_arvalid) rd_tgt_r <= 5'(RD_LAT) + {1'b0, lfsr_r[3:0]};
      if (wr_both_s)                             wr_tgt_r <= 5'(WR_LAT) + {1'b0, lfsr_r[3:0]};
    end
  end
  assign rd_tgt_s = rd_tgt_r;
  assign wr_tgt_s = wr_tgt_r;
`else
  assign rd_tgt_s = 5'(RD_LAT);
  assign wr_tgt_s = 5'(WR_LAT);
`endif

  // Read channel FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_r <= R_IDLE;
      rd_addr_r  <= '0;
      rd_cnt_r   <= 5'd0;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      rdata_r    <= '0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (mem_arvalid) begin
            rd_addr_r  <= mem_araddr;
            rd_cnt_r   <= 5'd0;
            arready_r  <= 1'b0;
            rd_state_r <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rd_done_s) begin
            // Nonblocking read gives old data on a same-edge write commit.
            rdata_r    <= rd_hit_s ? mem_r[rd_idx_s] : '0;
            rresp_r    <= rd_hit_s ? RESP_OKAY : RESP_DECERR;
            rvalid_r   <= 1'b1;
            rd_cnt_r   <= 5'd0;
            rd_state_r <= R_RESP;
          end else begin
            rd_cnt_r <= rd_cnt_r + 5'd1;
          end
        end
        R_RESP: begin
          if (mem_rready) begin
            rvalid_r   <= 1'b0;
            arready_r  <= 1'b1;
            rd_state_r <= R_IDLE;
          end
        end
        default: begin
          rvalid_r   <= 1'b0;
          arready_r  <= 1'b1;
          rd_cnt_r   <= 5'd0;
          rd_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Write channel FSM: independent AW/W capture, wait, commit, response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      wr_strb_r  <= '0;
      wr_cnt_r   <= 5'd0;
      awready_r  <= 1'b1;
      wready_r   <= 1'b1;
      bvalid_r   <= 1'b0;
      bresp_r    <= RESP_OKAY;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (aw_take_s) begin
            wr_addr_r <= mem_awaddr;
            awready_r <= 1'b0;
          end
          if (w_take_s) begin
            wr_data_r <= mem_wdata;
            wr_strb_r <= mem_wstrb;
            wready_r  <= 1'b0;
          end
          if (wr_both_s) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b0;
            wr_cnt_r   <= 5'd0;
            wr_state_r <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (wr_done_s) begin
            bresp_r    <= wr_hit_s ? RESP_OKAY : RESP_DECERR;
            bvalid_r   <= 1'b1;
            wr_cnt_r   <= 5'd0;
            wr_state_r <= W_RESP;
          end else begin
            wr_cnt_r <= wr_cnt_r + 5'd1;
          end
        end
        W_RESP: begin
          if (mem_bready) begin
            bvalid_r   <= 1'b0;
            awready_r  <= 1'b1;
            wready_r   <= 1'b1;
            wr_state_r <= W_IDLE;
          end
        end
        default: begin
          bvalid_r   <= 1'b0;
          awready_r  <= 1'b1;
          wready_r   <= 1'b1;
          wr_cnt_r   <= 5'd0;
          wr_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Storage array; written only on the commit edge of an in-range write.
  always_ff @(posedge clk) begin
    if (wr_commit_s) mem_r[wr_idx_s] <= merge_bytes(mem_r[wr_idx_s], wr_data_r, wr_strb_r);
  end

  assign mem_arready = arready_r;
  assign mem_rvalid  = rvalid_r;
  assign mem_rresp   = rresp_r;
  assign mem_rdata   = rdata_r;
  assign mem_awready = awready_r;
  assign mem_wready  = wready_r;
  assign mem_bvalid  = bvalid_r;
  assign mem_bresp   = bresp_r;

endmodule
